// File: rtl/alt_slot_scheduler.sv
// rtl/alt_slot_scheduler.sv - alternating-slot scheduler sharing one output register between requesters A and B
//
// Optional feature macro: SLOT_BORROW_EN (work-conserving borrowing of an idle slot's last cycle)
//
// Ports:
//   clk                      sole clock, rising edge
//   reset                    asynchronous, active-low; clears all state
//   enable                   run request; slot in progress finishes, then IDLE
//   div[DIV_W]               slot length minus one, sampled at each slot start
//   a_valid/a_data/a_ready   requester A offer and grant
//   b_valid/b_data/b_ready   requester B offer and grant
//   clk_out                  registered slot phase (0 = slot A or idle, 1 = slot B)
//   out_valid/out_data/out_src/out_ready  registered output channel
module alt_slot_scheduler #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             clk_out,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SLOT_A = 2'd1,
    SLOT_B = 2'd2
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic             served;

  logic free;
  logic last;
  logic slot_open;
  logic a_own;
  logic b_own;
  logic a_borrow;
  logic b_borrow;

  // Output register can take a word when empty or being drained this cycle.
  assign free      = !out_valid || out_ready;
  assign last      = (cnt == div_q);
  assign slot_open = enable && !served && free;

  assign a_own = slot_open && (state == SLOT_A) && a_valid;
  assign b_own = slot_open && (state == SLOT_B) && b_valid;

`ifdef SLOT_BORROW_EN
  // Non-owner may take the slot's last cycle when the owner has nothing to send;
  // the owner's own valid already excludes it, so owner priority is preserved.
  assign a_borrow = slot_open && last && (state == SLOT_B) && !b_valid && a_valid;
  assign b_borrow = slot_open && last && (state == SLOT_A) && !a_valid && b_valid;
`else
  assign a_borrow = 1'b0;
  assign b_borrow = 1'b0;
`endif

  assign a_ready = a_own || a_borrow;
  assign b_ready = b_own || b_borrow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      div_q     <= '0;
      served    <= 1'b0;
      clk_out   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state   <= SLOT_A;
            cnt     <= '0;
            div_q   <= div;
            served  <= 1'b0;
            clk_out <= 1'b0;
          end
        end
        SLOT_A, SLOT_B: begin
          if (last) begin
            // Slot boundary: a transfer in this cycle belongs to the ending slot,
            // so served is simply cleared for the next one.
            cnt    <= '0;
            div_q  <= div;
            served <= 1'b0;
            if (enable) begin
              state   <= (state == SLOT_A) ? SLOT_B : SLOT_A;
              clk_out <= (state == SLOT_A);
            end else begin
              state   <= IDLE;
              clk_out <= 1'b0;
            end
          end else begin
            cnt <= cnt + DIV_W'(1);
            if (a_ready || b_ready) begin
              served <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          clk_out <= 1'b0;
        end
      endcase

      // A load takes precedence over a drain; a simultaneous drain and load
      // keeps out_valid high with the new word.
      if (a_ready) begin
        out_valid <= 1'b1;
        out_data  <= a_data;
        out_src   <= 1'b0;
      end else if (b_ready) begin
        out_valid <= 1'b1;
        out_data  <= b_data;
        out_src   <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alt_slot_scheduler.sv
// tb/tb_alt_slot_scheduler.sv - directed self-checking bench for alt_slot_scheduler
module tb_alt_slot_scheduler;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic [D-1:0] div = '0;
  logic         a_valid = 1'b0;
  logic [W-1:0] a_data = '0;
  logic         a_ready;
  logic         b_valid = 1'b0;
  logic [W-1:0] b_data = '0;
  logic         b_ready;
  logic         clk_out;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_src;
  logic         out_ready = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  alt_slot_scheduler #(.WIDTH(W), .DIV_W(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .div       (div),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .clk_out   (clk_out),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  // Reset pulse, then enable in the same cycle: this becomes cycle 0 (IDLE).
  task automatic start(input logic [D-1:0] d);
    next_cycle();
    reset = 1'b0;
    #1;
    reset  = 1'b1;
    enable = 1'b1;
    div    = d;
  endtask

  initial begin
    // Power-on reset with inputs active
    a_valid = 1'b1;
    enable  = 1'b1;
    next_cycle();
    next_cycle();
    settle();
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_data",  32'(out_data),  32'(0));
    check("rst_clk_out",   32'(clk_out),   32'(0));
    check("rst_a_ready",   32'(a_ready),   32'(0));

    // Reset mid-slot (slot B, out_valid=1)
    a_data = 8'h3C; b_valid = 1'b0; out_ready = 1'b0;
    start(4'd0);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) next_cycle();
      settle();
      if (c == 1) check("rm_a_ready", 32'(a_ready), 32'(1));
    end
    check("rm_pre_clk_out",   32'(clk_out),   32'(1));
    check("rm_pre_out_valid", 32'(out_valid), 32'(1));
    reset = 1'b0;
    #1;
    check("rm_out_valid", 32'(out_valid), 32'(0));
    check("rm_out_data",  32'(out_data),  32'(0));
    check("rm_clk_out",   32'(clk_out),   32'(0));
    check("rm_a_ready",   32'(a_ready),   32'(0));
    reset = 1'b1;
    next_cycle();
    settle();
    check("rm_post_clk_out", 32'(clk_out), 32'(0));
    check("rm_post_a_ready", 32'(a_ready), 32'(1));

    // Alternation at div=3, both valid, no stall
    a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
    a_data = 8'hA5; b_data = 8'h5B;
    start(4'd3);
    for (int c = 0; c < 20; c++) begin
      if (c > 0) next_cycle();
      settle();
      check("alt_a_ready", 32'(a_ready), 32'(c == 1 || c == 9 || c == 17));
      check("alt_b_ready", 32'(b_ready), 32'(c == 5 || c == 13));
      check("alt_clk_out", 32'(clk_out), 32'(c >= 1 && ((c - 1) / 4) % 2 == 1));
      if (c == 2 || c == 6 || c == 10 || c == 14) begin
        check("alt_out_valid", 32'(out_valid), 32'(1));
        check("alt_out_src",   32'(out_src),   32'(c == 6 || c == 14));
        check("alt_out_data",  32'(out_data),  (c == 6 || c == 14) ? 32'h5B : 32'hA5);
      end
      if (c == 3) check("alt_drain", 32'(out_valid), 32'(0));
    end

    // Backpressure at div=1: out_ready low in cycles 2..7
    a_data = 8'h11; b_data = 8'h22; out_ready = 1'b1;
    start(4'd1);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) next_cycle();
      out_ready = !(c >= 2 && c <= 7);
      settle();
      check("bp_a_ready", 32'(a_ready), 32'(c == 1 || c == 9));
      check("bp_b_ready", 32'(b_ready), 32'(c == 8));
      if (c >= 2 && c <= 8) begin
        check("bp_out_valid", 32'(out_valid), 32'(1));
        check("bp_out_data",  32'(out_data),  32'h11);
      end
      if (c == 9) begin
        check("bp_new_data", 32'(out_data), 32'h22);
        check("bp_new_src",  32'(out_src),  32'(1));
      end
    end

    // div change 1 -> 0 mid-slot
    out_ready = 1'b1;
    start(4'd1);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) next_cycle();
      if (c == 1) div = 4'd0;
      settle();
      check("dc_clk_out", 32'(clk_out), 32'(c >= 3 && (c % 2) == 1));
      check("dc_a_ready", 32'(a_ready), 32'(c == 1 || (c >= 3 && (c % 2) == 0)));
      check("dc_b_ready", 32'(b_ready), 32'(c >= 3 && (c % 2) == 1));
    end

    // Borrow: div=2, only B valid
    a_valid = 1'b0; b_valid = 1'b1; out_ready = 1'b1;
    start(4'd2);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) next_cycle();
      settle();
`ifdef SLOT_BORROW_EN
      check("bw_b_ready", 32'(b_ready), 32'(c == 3 || c == 4 || c == 9 || c == 10));
`else
      check("bw_b_ready", 32'(b_ready), 32'(c == 4 || c == 10));
`endif
      check("bw_a_ready", 32'(a_ready), 32'(0));
    end

    // Enable drop at counter 1 of slot B (div=3)
    a_valid = 1'b1; b_valid = 1'b0; out_ready = 1'b1;
    start(4'd3);
    for (int c = 0; c < 11; c++) begin
      if (c > 0) next_cycle();
      if (c == 6) begin
        b_valid = 1'b1;
        enable  = 1'b0;
      end
      settle();
      if (c == 1) check("en_a_ready", 32'(a_ready), 32'(1));
      if (c >= 6) begin
        check("en_b_ready", 32'(b_ready), 32'(0));
        check("en_a_off",   32'(a_ready), 32'(0));
        check("en_clk_out", 32'(clk_out), 32'(c <= 8));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
